dormir_test: RTL and testbench

//  Pet-state FSM for the Tamagotchi core: energy, food and fun levels, sleep handling, death timeout.

---
 rtl/dormir_test.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_dormir_test.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dormir_test.sv
// -----------------------------------------------------------------------------
// dormir_test
// Pet-state FSM for the Tamagotchi core. It tracks energy, food and fun levels,
// handles sleeping and playing, and moves the pet to DEATH after a starvation
// timeout. Levels decay or recover only on a slow internal tick, which is a
// one-cycle pulse produced when the clk prescaler wraps.
//
// Parameters
//   TICK_CYCLES  clk cycles per tick
//   ENERGY_MAX   maximum energy level (reset value)
//   FOOD_MAX     maximum food level (reset value)
//   FUN_MAX      maximum fun level (reset value)
//   DEATH_TICKS  consecutive ticks at food==0 before DEATH
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active low
//   botonSleep   in   sleep request, acts on its rising edge
//   botonAwake   in   wake request, acts on its rising edge
//   botonFeed    in   feed, acts on its rising edge
//   botonPlay    in   play toggle, acts on its rising edge
//   giro         in   tilt/shake sensor level, sampled on tick
//   sign_*       out  nine registered one-hot state flags
//
// Configuration macro: DORMIR_GIRO_EN
//   Defined:   on a tick, giro=1 wakes the pet from SLEEP, and giro=1 in a
//              mood state adds one fun point.
//   Undefined: giro is ignored; the port is kept for interface compatibility.
// -----------------------------------------------------------------------------
module dormir_test #(
    parameter int TICK_CYCLES = 5,
    parameter int ENERGY_MAX  = 4,
    parameter int FOOD_MAX    = 4,
    parameter int FUN_MAX     = 4,
    parameter int DEATH_TICKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic botonSleep,
    input  logic botonAwake,
    input  logic botonFeed,
    input  logic botonPlay,
    input  logic giro,
    output logic sign_IDLE,
    output logic sign_SLEEP,
    output logic sign_NEUTRAL,
    output logic sign_TIRED,
    output logic sign_DEATH,
    output logic sign_HUNGRY,
    output logic sign_SAD,
    output logic sign_PLAYING,
    output logic sign_BORED
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int EW = $clog2(ENERGY_MAX + 1);
    localparam int FW = $clog2(FOOD_MAX + 1);
    localparam int UW = $clog2(FUN_MAX + 1);
    localparam int SW = $clog2(DEATH_TICKS + 1);

    // Button vector bit positions
    localparam int B_SLEEP = 0;
    localparam int B_AWAKE = 1;
    localparam int B_FEED  = 2;
    localparam int B_PLAY  = 3;

    // The state encoding is itself one-hot, so the flags are simply the bits
    // of the state register.
    typedef enum logic [8:0] {
        S_IDLE    = 9'h001,
        S_SLEEP   = 9'h002,
        S_NEUTRAL = 9'h004,
        S_TIRED   = 9'h008,
        S_DEATH   = 9'h010,
        S_HUNGRY  = 9'h020,
        S_SAD     = 9'h040,
        S_PLAYING = 9'h080,
        S_BORED   = 9'h100
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    state_t         w_mood_nxt;

    logic [PW-1:0]  r_presc;
    logic           w_tick;

    logic [3:0]     r_btn_q;
    logic [3:0]     w_btn;
    logic [3:0]     w_edge;
    logic           w_sleep_ev;
    logic           w_awake_ev;
    logic           w_feed_ev;
    logic           w_play_ev;
    logic           w_giro_wake;
    logic           w_is_mood;

    logic [EW-1:0]  r_energy;
    logic [FW-1:0]  r_food;
    logic [UW-1:0]  r_fun;
    logic [SW-1:0]  r_starve;
    logic [EW-1:0]  w_energy_nxt;
    logic [FW-1:0]  w_food_nxt;
    logic [UW-1:0]  w_fun_nxt;
    logic [SW-1:0]  w_starve_nxt;

    logic           w_e_inc;
    logic           w_e_dec;
    logic           w_fd_dec;
    logic           w_fun_inc;
    logic           w_fun_dec;

    // Add/subtract one-step deltas and clamp the result to [0, mx].
    function automatic int sat_step(input int v, input int inc, input int dec, input int mx);
        int t;
        t = v + inc - dec;
        if (t < 0)
            t = 0;
        else if (t > mx)
            t = mx;
        return t;
    endfunction

    // Awake mood from the levels, highest priority first.
    function automatic state_t mood_of(input logic [SW-1:0] st, input logic [EW-1:0] en,
                                       input logic [FW-1:0] fd, input logic [UW-1:0] fn);
        if (st == SW'(DEATH_TICKS))
            return S_DEATH;
        else if (fd <= FW'(1))
            return S_HUNGRY;
        else if (en <= EW'(1))
            return S_TIRED;
        else if (fn == '0)
            return S_SAD;
        else if (fn <= UW'(1))
            return S_BORED;
        else
            return S_NEUTRAL;
    endfunction

    // Tick prescaler
    assign w_tick = (r_presc == PW'(TICK_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_presc <= '0;
        else if (w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + PW'(1);
    end

    // Edge detectors; the history resets to 0 so a button held through reset
    // release is seen as one press.
    assign w_btn  = {botonPlay, botonFeed, botonAwake, botonSleep};
    assign w_edge = w_btn & ~r_btn_q;

    assign w_sleep_ev = w_edge[B_SLEEP];
    assign w_awake_ev = w_edge[B_AWAKE];
    assign w_play_ev  = w_edge[B_PLAY];
    assign w_feed_ev  = w_edge[B_FEED] && (r_state != S_DEATH);

    assign w_is_mood = (r_state == S_NEUTRAL) || (r_state == S_TIRED) ||
                       (r_state == S_HUNGRY)  || (r_state == S_SAD)   ||
                       (r_state == S_BORED);

`ifdef DORMIR_GIRO_EN
    assign w_giro_wake = w_tick && giro && (r_state == S_SLEEP);
`else
    logic w_unused_giro;
    assign w_unused_giro = giro;
    assign w_giro_wake   = 1'b0;
`endif

    // Per-tick level deltas for the current state. IDLE and DEATH hold levels.
    always_comb begin
        w_e_inc   = 1'b0;
        w_e_dec   = 1'b0;
        w_fd_dec  = 1'b0;
        w_fun_inc = 1'b0;
        w_fun_dec = 1'b0;
        if (w_tick) begin
            if (r_state == S_SLEEP) begin
                w_e_inc  = 1'b1;
                w_fd_dec = 1'b1;
            end else if (r_state == S_PLAYING) begin
                w_fun_inc = 1'b1;
                w_e_dec   = 1'b1;
                w_fd_dec  = 1'b1;
            end else if (w_is_mood) begin
                w_e_dec   = 1'b1;
                w_fd_dec  = 1'b1;
                w_fun_dec = 1'b1;
`ifdef DORMIR_GIRO_EN
                w_fun_inc = giro;
`endif
            end
        end
    end

    // Feed and tick decay may coincide; they are summed before clamping.
    assign w_energy_nxt = EW'(sat_step(int'(r_energy), int'(w_e_inc), int'(w_e_dec), ENERGY_MAX));
    assign w_food_nxt   = FW'(sat_step(int'(r_food), int'(w_feed_ev), int'(w_fd_dec), FOOD_MAX));
    assign w_fun_nxt    = UW'(sat_step(int'(r_fun), int'(w_fun_inc), int'(w_fun_dec), FUN_MAX));

    // Starvation counts ticks that begin with food already at 0, so the tick
    // that empties the stomach is not counted.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_food_nxt != '0)
            w_starve_nxt = '0;
        else if (w_tick && (r_food == '0) && (r_starve != SW'(DEATH_TICKS)))
            w_starve_nxt = r_starve + SW'(1);
    end

    // The mood is judged on the levels being written this cycle, so flags and
    // levels always change together.
    assign w_mood_nxt = mood_of(w_starve_nxt, w_energy_nxt, w_food_nxt, w_fun_nxt);

    // Next-state logic. Button edges outrank tick-driven exits; among the
    // transition buttons Awake outranks Sleep, which outranks Play.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_tick || (|w_edge))
                    w_state_nxt = w_mood_nxt;
            end
            S_DEATH: begin
                w_state_nxt = S_DEATH;
            end
            S_SLEEP: begin
                // Full-energy wake-up is checked on ticks only, so a pet sent
                // to bed at full energy still sleeps until the next tick.
                if (w_awake_ev || w_giro_wake ||
                    (w_tick && (w_energy_nxt == EW'(ENERGY_MAX))))
                    w_state_nxt = w_mood_nxt;
            end
            S_PLAYING: begin
                if (w_awake_ev)
                    w_state_nxt = S_PLAYING;
                else if (w_sleep_ev)
                    w_state_nxt = S_SLEEP;
                else if (w_play_ev ||
                         (w_tick && ((w_fun_nxt == UW'(FUN_MAX)) || (w_energy_nxt == '0))))
                    w_state_nxt = w_mood_nxt;
            end
            default: begin
                if (w_awake_ev)
                    w_state_nxt = w_mood_nxt;
                else if (w_sleep_ev)
                    w_state_nxt = S_SLEEP;
                else if (w_play_ev && (r_state != S_TIRED) && (r_state != S_HUNGRY))
                    w_state_nxt = S_PLAYING;
                else
                    w_state_nxt = w_mood_nxt;
            end
        endcase
        // Starvation ends the game from any active state.
        if ((r_state != S_IDLE) && (w_starve_nxt == SW'(DEATH_TICKS)))
            w_state_nxt = S_DEATH;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_btn_q  <= '0;
            r_energy <= EW'(ENERGY_MAX);
            r_food   <= FW'(FOOD_MAX);
            r_fun    <= UW'(FUN_MAX);
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_btn_q  <= w_btn;
            r_energy <= w_energy_nxt;
            r_food   <= w_food_nxt;
            r_fun    <= w_fun_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    assign sign_IDLE    = r_state[0];
    assign sign_SLEEP   = r_state[1];
    assign sign_NEUTRAL = r_state[2];
    assign sign_TIRED   = r_state[3];
    assign sign_DEATH   = r_state[4];
    assign sign_HUNGRY  = r_state[5];
    assign sign_SAD     = r_state[6];
    assign sign_PLAYING = r_state[7];
    assign sign_BORED   = r_state[8];

endmodule

// File: tb/tb_dormir_test.sv
// -----------------------------------------------------------------------------
// tb_dormir_test
// Directed, table-driven bench for dormir_test with default parameters
// (tick every 5 clk, levels 4, death after 20 starving ticks). Each record holds
// the button/giro levels, how many clocks to hold them and the expected flag
// word afterwards. Cycle counts in the comments are clk edges since reset
// release; ticks land on edges 5, 10, 15, ...
// -----------------------------------------------------------------------------
module tb_dormir_test;

    localparam logic [8:0] F_IDLE = 9'h001;
    localparam logic [8:0] F_SLP  = 9'h002;
    localparam logic [8:0] F_NEU  = 9'h004;
    localparam logic [8:0] F_TIR  = 9'h008;
    localparam logic [8:0] F_DTH  = 9'h010;
    localparam logic [8:0] F_HUN  = 9'h020;
    localparam logic [8:0] F_SAD  = 9'h040;
    localparam logic [8:0] F_PLY  = 9'h080;
    localparam logic [8:0] F_BOR  = 9'h100;

    typedef struct {
        logic       s;
        logic       a;
        logic       f;
        logic       p;
        logic       g;
        int         n;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic botonSleep = 1'b0;
    logic botonAwake = 1'b0;
    logic botonFeed  = 1'b0;
    logic botonPlay  = 1'b0;
    logic giro       = 1'b0;
    logic sign_IDLE, sign_SLEEP, sign_NEUTRAL, sign_TIRED, sign_DEATH;
    logic sign_HUNGRY, sign_SAD, sign_PLAYING, sign_BORED;
    logic [8:0] flags;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dormir_test dut (
        .clk          (clk),
        .rst          (rst),
        .botonSleep   (botonSleep),
        .botonAwake   (botonAwake),
        .botonFeed    (botonFeed),
        .botonPlay    (botonPlay),
        .giro         (giro),
        .sign_IDLE    (sign_IDLE),
        .sign_SLEEP   (sign_SLEEP),
        .sign_NEUTRAL (sign_NEUTRAL),
        .sign_TIRED   (sign_TIRED),
        .sign_DEATH   (sign_DEATH),
        .sign_HUNGRY  (sign_HUNGRY),
        .sign_SAD     (sign_SAD),
        .sign_PLAYING (sign_PLAYING),
        .sign_BORED   (sign_BORED)
    );

    assign flags = {sign_BORED, sign_PLAYING, sign_SAD, sign_HUNGRY, sign_DEATH,
                    sign_TIRED, sign_NEUTRAL, sign_SLEEP, sign_IDLE};

    task automatic add(input logic s, input logic a, input logic f, input logic p,
                       input logic g, input int n, input logic [8:0] e);
        vec_t v;
        v.s = s; v.a = a; v.f = f; v.p = p; v.g = g; v.n = n; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic check(input string tag, input logic [8:0] e);
        n_vec++;
        if (flags !== e) begin
            n_bad++;
            $display("FAIL %s: flags=%b expected %b", tag, flags, e);
        end
    endtask

    // Called at a falling edge: drive, let n rising edges pass, compare.
    task automatic run_vecs(input string name);
        foreach (vq[i]) begin
            botonSleep = vq[i].s;
            botonAwake = vq[i].a;
            botonFeed  = vq[i].f;
            botonPlay  = vq[i].p;
            giro       = vq[i].g;
            repeat (vq[i].n) @(negedge clk);
            check($sformatf("%s[%0d]", name, i), vq[i].exp);
        end
        vq.delete();
    endtask

    // Hold reset for three cycles with the given sleep level, release on a falling edge.
    task automatic do_reset(input logic sleep_lvl);
        rst = 1'b0;
        botonSleep = sleep_lvl;
        botonAwake = 1'b0;
        botonFeed  = 1'b0;
        botonPlay  = 1'b0;
        giro       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Run A: wake-up, decay to HUNGRY, feeding, sleeping, playing to energy 0.
        do_reset(1'b0);
        add(0,0,0,0,0, 0, F_IDLE);  // c0  reset state
        add(0,0,0,0,0, 4, F_IDLE);  // c4  no tick yet
        add(0,0,0,0,0, 1, F_NEU);   // c5  first tick, levels stay 4/4/4
        add(0,0,0,0,1, 5, F_NEU);   // c10 3/3/3, giro ignored
        add(0,0,0,0,1, 5, F_NEU);   // c15 2/2/2
        add(0,0,0,0,1, 5, F_HUN);   // c20 1/1/1, hunger outranks tired/bored
        add(0,0,0,1,0, 1, F_HUN);   // c21 play refused while hungry
        add(0,0,0,0,0, 1, F_HUN);   // c22
        add(0,0,1,0,0, 1, F_TIR);   // c23 food 2 -> tired
        add(0,0,0,0,0, 1, F_TIR);   // c24
        add(0,0,1,0,0, 1, F_TIR);   // c25 feed + tick: e0 f2 fun0
        add(0,0,0,0,0, 1, F_TIR);   // c26
        add(0,0,1,0,0, 1, F_TIR);   // c27 food 3
        add(0,0,0,0,0, 1, F_TIR);   // c28
        add(1,0,0,0,0, 1, F_SLP);   // c29 sleep edge
        add(1,0,0,0,0, 1, F_SLP);   // c30 tick: e1 f2
        add(1,0,1,0,0, 1, F_SLP);   // c31 f3
        add(1,0,0,0,0, 1, F_SLP);   // c32
        add(1,0,1,0,0, 1, F_SLP);   // c33 f4
        add(1,0,0,0,0, 1, F_SLP);   // c34
        add(1,0,1,0,0, 1, F_SLP);   // c35 tick + feed: e2 f4 (saturated)
        add(1,0,0,0,0, 1, F_SLP);   // c36
        add(1,1,0,0,0, 1, F_SAD);   // c37 awake: e2 f4 fun0
        add(0,0,0,0,0, 1, F_SAD);   // c38
        add(0,0,0,1,0, 1, F_PLY);   // c39 play from SAD
        add(0,0,0,1,0, 1, F_PLY);   // c40 tick: fun1 e1 f3
        add(0,0,0,0,0, 4, F_PLY);   // c44
        add(0,0,0,0,0, 1, F_TIR);   // c45 tick: e0 ends play
        run_vecs("runA");

        // Run B: starvation, feed clears the counter, then death is sticky.
        do_reset(1'b0);
        add(0,0,0,0,0, 24,  F_HUN); // c24 levels 1/1/1
        add(0,0,0,0,0, 1,   F_HUN); // c25 levels 0/0/0
        add(0,0,0,0,0, 45,  F_HUN); // c70 starve 9
        add(0,0,1,0,0, 1,   F_HUN); // c71 food 1, starve cleared
        add(0,0,0,0,0, 103, F_HUN); // c174 starve 19
        add(0,0,0,0,0, 1,   F_DTH); // c175 starve 20
        add(1,0,1,1,0, 1,   F_DTH);
        add(0,1,0,0,0, 1,   F_DTH);
        add(0,0,1,0,0, 1,   F_DTH);
        add(0,0,0,1,0, 7,   F_DTH);
        run_vecs("runB");

        // Run C: play until fun is full, Sleep beats Play, wake at full energy.
        do_reset(1'b0);
        add(0,0,0,0,0, 5, F_NEU);   // c5
        add(0,0,0,0,0, 5, F_NEU);   // c10 3/3/3
        add(0,0,0,1,0, 1, F_PLY);   // c11
        add(0,0,0,0,0, 3, F_PLY);   // c14
        add(0,0,0,0,0, 1, F_NEU);   // c15 fun4 e2 f2 -> leaves play
        add(1,0,0,1,0, 1, F_SLP);   // c16 sleep and play together
        add(0,0,0,0,0, 4, F_SLP);   // c20 e3 f1
        add(0,0,0,0,0, 4, F_SLP);   // c24
        add(0,0,0,0,0, 1, F_HUN);   // c25 e4 f0 -> wakes hungry
        run_vecs("runC");

        // Run D: sleep held through reset fires once; reset mid-sleep.
        do_reset(1'b1);
        add(1,0,0,0,0, 1, F_NEU);   // c1 held button leaves IDLE
        add(1,0,0,0,0, 1, F_NEU);   // c2 no second event
        add(0,0,0,0,0, 8, F_NEU);   // c10 2/2/2
        add(1,0,0,0,0, 1, F_SLP);   // c11
        run_vecs("runD");
        rst = 1'b0;
        #1;
        check("rst_async_idle", F_IDLE);
        @(negedge clk);
        botonSleep = 1'b0;
        rst = 1'b1;
        add(0,0,0,0,0, 0,  F_IDLE); // c0 after release
        add(0,0,0,0,0, 5,  F_NEU);  // c5 levels back at 4
        add(0,0,0,0,0, 14, F_NEU);  // c19 2/2/2
        add(0,0,0,0,0, 1,  F_HUN);  // c20 1/1/1
        run_vecs("runD2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog: the directed runs take well under 1000 cycles.
    initial begin
        #20000;
        $display("FAIL watchdog: time=%0t limit=%0d", $time, 20000);
        $fatal(1, "timeout");
    end

endmodule
